// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, a 33-cycle
// shift-add multiplier that stalls the front end, and the EX/MEM register.
module ex_stage (
    input  logic        CLK,
    input  logic        Resetn,
    input  logic [31:0] busA_EX,
    input  logic [31:0] busB_EX,
    input  logic [31:0] PC_EX,
    input  logic [31:0] imm_EX,
    input  logic [4:0]  Ra_EX,
    input  logic [4:0]  Rb_EX,
    input  logic [4:0]  Rd_EX,
    input  logic [3:0]  ALUctr_EX,
    input  logic        ALUASrc_EX,
    input  logic [1:0]  ALUBSrc_EX,
    input  logic        Branch_EX,
    input  logic        Jump_EX,
    input  logic        MemWr_EX,
    input  logic        MemRead_EX,
    input  logic        MemtoReg_EX,
    input  logic        RegWr_EX,
    input  logic        RegWr_WB,
    input  logic [4:0]  Rd_WB,
    input  logic [31:0] busW_WB,
    output logic [31:0] ALUout_MEM,
    output logic [31:0] busB_MEM,
    output logic [4:0]  Rd_MEM,
    output logic        RegWr_MEM,
    output logic        MemWr_MEM,
    output logic        MemRead_MEM,
    output logic        MemtoReg_MEM,
    output logic        Redirect_EX,
    output logic [31:0] Target_EX,
    output logic        Stall_EX
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_state_t;

    mul_state_t  mul_state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] product;
    logic [4:0]  step;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_result;
    logic        is_mul;
    logic        taken;

    // MEM beats WB; register 0 is hard-wired and never forwarded.
    always_comb begin
        fwd_a = busA_EX;
        if (RegWr_MEM && (Rd_MEM != 5'd0) && (Rd_MEM == Ra_EX))
            fwd_a = ALUout_MEM;
        else if (RegWr_WB && (Rd_WB != 5'd0) && (Rd_WB == Ra_EX))
            fwd_a = busW_WB;
    end

    always_comb begin
        fwd_b = busB_EX;
        if (RegWr_MEM && (Rd_MEM != 5'd0) && (Rd_MEM == Rb_EX))
            fwd_b = ALUout_MEM;
        else if (RegWr_WB && (Rd_WB != 5'd0) && (Rd_WB == Rb_EX))
            fwd_b = busW_WB;
    end

    always_comb begin
        op_a = ALUASrc_EX ? PC_EX : fwd_a;
        case (ALUBSrc_EX)
            2'b00:   op_b = fwd_b;
            2'b10:   op_b = 32'd4;
            default: op_b = imm_EX;
        endcase
    end

    assign is_mul = (ALUctr_EX == OP_MUL);

    always_comb begin
        alu_result = op_a + op_b;
        case (ALUctr_EX)
            OP_SUB:   alu_result = op_a - op_b;
            OP_AND:   alu_result = op_a & op_b;
            OP_OR:    alu_result = op_a | op_b;
            OP_XOR:   alu_result = op_a ^ op_b;
            OP_SLL:   alu_result = op_a << op_b[4:0];
            OP_SRL:   alu_result = op_a >> op_b[4:0];
            OP_SRA:   alu_result = $signed(op_a) >>> op_b[4:0];
            OP_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_result = {31'd0, op_a < op_b};
            OP_PASSB: alu_result = op_b;
            OP_MUL:   alu_result = product;
            default:  alu_result = op_a + op_b;
        endcase
    end

    // Operands are captured at start so forwarding changes mid-multiply are ignored.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            mul_state <= IDLE;
            mcand     <= 32'd0;
            mplier    <= 32'd0;
            product   <= 32'd0;
            step      <= 5'd0;
        end else begin
            case (mul_state)
                IDLE: begin
                    if (is_mul) begin
                        mcand     <= fwd_a;
                        mplier    <= fwd_b;
                        product   <= 32'd0;
                        step      <= 5'd0;
                        mul_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (mcand[0])
                        product <= product + (mplier << step);
                    mcand <= mcand >> 1;
                    step  <= step + 5'd1;
                    if (step == 5'd31)
                        mul_state <= DONE;
                end
                DONE: begin
                    mul_state <= IDLE;
                end
                default: begin
                    mul_state <= IDLE;
                end
            endcase
        end
    end

    assign Stall_EX    = ((mul_state == IDLE) && is_mul) || (mul_state == BUSY);
    assign taken       = Jump_EX | (Branch_EX & (fwd_a == fwd_b));
    assign Redirect_EX = taken & ~Stall_EX;
    assign Target_EX   = PC_EX + imm_EX;

    // A stalled cycle inserts a bubble so the memory stage sees no side effects.
    always_ff @(negedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            ALUout_MEM   <= 32'd0;
            busB_MEM     <= 32'd0;
            Rd_MEM       <= 5'd0;
            RegWr_MEM    <= 1'b0;
            MemWr_MEM    <= 1'b0;
            MemRead_MEM  <= 1'b0;
            MemtoReg_MEM <= 1'b0;
        end else if (Stall_EX) begin
            ALUout_MEM   <= 32'd0;
            busB_MEM     <= 32'd0;
            Rd_MEM       <= 5'd0;
            RegWr_MEM    <= 1'b0;
            MemWr_MEM    <= 1'b0;
            MemRead_MEM  <= 1'b0;
            MemtoReg_MEM <= 1'b0;
        end else begin
            ALUout_MEM   <= alu_result;
            busB_MEM     <= fwd_b;
            Rd_MEM       <= Rd_EX;
            RegWr_MEM    <= RegWr_EX;
            MemWr_MEM    <= MemWr_EX;
            MemRead_MEM  <= MemRead_EX;
            MemtoReg_MEM <= MemtoReg_EX;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM contents are queued at issue
// and a monitor compares them whenever the EX/MEM register carries an instruction.
module tb_ex_stage;

    logic        CLK;
    logic        Resetn;
    logic [31:0] busA_EX, busB_EX, PC_EX, imm_EX;
    logic [4:0]  Ra_EX, Rb_EX, Rd_EX;
    logic [3:0]  ALUctr_EX;
    logic        ALUASrc_EX;
    logic [1:0]  ALUBSrc_EX;
    logic        Branch_EX, Jump_EX, MemWr_EX, MemRead_EX, MemtoReg_EX, RegWr_EX;
    logic        RegWr_WB;
    logic [4:0]  Rd_WB;
    logic [31:0] busW_WB;
    logic [31:0] ALUout_MEM, busB_MEM;
    logic [4:0]  Rd_MEM;
    logic        RegWr_MEM, MemWr_MEM, MemRead_MEM, MemtoReg_MEM;
    logic        Redirect_EX;
    logic [31:0] Target_EX;
    logic        Stall_EX;

    logic [72:0] exp_q[$];
    logic [72:0] act_pack;
    int          n_total = 0;
    int          n_pass  = 0;

    ex_stage dut (
        .CLK(CLK), .Resetn(Resetn),
        .busA_EX(busA_EX), .busB_EX(busB_EX), .PC_EX(PC_EX), .imm_EX(imm_EX),
        .Ra_EX(Ra_EX), .Rb_EX(Rb_EX), .Rd_EX(Rd_EX),
        .ALUctr_EX(ALUctr_EX), .ALUASrc_EX(ALUASrc_EX), .ALUBSrc_EX(ALUBSrc_EX),
        .Branch_EX(Branch_EX), .Jump_EX(Jump_EX), .MemWr_EX(MemWr_EX),
        .MemRead_EX(MemRead_EX), .MemtoReg_EX(MemtoReg_EX), .RegWr_EX(RegWr_EX),
        .RegWr_WB(RegWr_WB), .Rd_WB(Rd_WB), .busW_WB(busW_WB),
        .ALUout_MEM(ALUout_MEM), .busB_MEM(busB_MEM), .Rd_MEM(Rd_MEM),
        .RegWr_MEM(RegWr_MEM), .MemWr_MEM(MemWr_MEM), .MemRead_MEM(MemRead_MEM),
        .MemtoReg_MEM(MemtoReg_MEM), .Redirect_EX(Redirect_EX),
        .Target_EX(Target_EX), .Stall_EX(Stall_EX)
    );

    assign act_pack = {ALUout_MEM, busB_MEM, Rd_MEM,
                       RegWr_MEM, MemWr_MEM, MemRead_MEM, MemtoReg_MEM};

    // Clock: DUT state moves on the falling edge; bench drives and samples near the rising edge.
    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic set_nop();
        busA_EX = 32'd0; busB_EX = 32'd0; PC_EX = 32'd0; imm_EX = 32'd0;
        Ra_EX = 5'd0; Rb_EX = 5'd0; Rd_EX = 5'd0;
        ALUctr_EX = 4'b0000; ALUASrc_EX = 1'b0; ALUBSrc_EX = 2'b00;
        Branch_EX = 1'b0; Jump_EX = 1'b0; MemWr_EX = 1'b0; MemRead_EX = 1'b0;
        MemtoReg_EX = 1'b0; RegWr_EX = 1'b0;
        RegWr_WB = 1'b0; Rd_WB = 5'd0; busW_WB = 32'd0;
    endtask

    // Called at a rising edge with the instruction already on the inputs.
    task automatic fire(input logic [31:0] exp_alu, input logic [31:0] exp_st);
        exp_q.push_back({exp_alu, exp_st, Rd_EX, RegWr_EX, MemWr_EX, MemRead_EX, MemtoReg_EX});
        @(negedge CLK);
        @(posedge CLK);
        set_nop();
    endtask

    task automatic advance();
        @(negedge CLK);
        @(posedge CLK);
        set_nop();
    endtask

    task automatic alu_op(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_alu);
        ALUctr_EX = ctr; busA_EX = a; busB_EX = b; Rd_EX = 5'd11; RegWr_EX = 1'b1;
        fire(exp_alu, b);
    endtask

    task automatic run_mul(input string name, input logic [31:0] exp_p, input logic [31:0] exp_st);
        int stalls;
        int bad;
        stalls = 0;
        bad    = 0;
        #1;
        while (Stall_EX === 1'b1 && stalls < 40) begin
            stalls++;
            @(posedge CLK);
            #1;
            if (act_pack !== 73'd0) bad++;
        end
        check({name, "_stall_cycles"}, 73'(stalls), 73'd33);
        check({name, "_bubbles"}, 73'(bad), 73'd0);
        fire(exp_p, exp_st);
    endtask

    // Monitor: any EX/MEM entry carrying a control bit must match the queue head.
    initial begin
        logic [72:0] exp_v;
        forever begin
            @(posedge CLK);
            #1;
            if (Resetn === 1'b1 && (RegWr_MEM || MemWr_MEM || MemRead_MEM || MemtoReg_MEM)) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_exmem: got 0x%0h expected no entry", act_pack);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("exmem", act_pack, exp_v);
                end
            end
        end
    end

    initial begin
        #100000;
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        Resetn = 1'b0;
        set_nop();
        repeat (2) @(posedge CLK);
        #1;
        check("reset_exmem", act_pack, 73'd0);
        check("reset_stall", 73'(Stall_EX), 73'd0);
        @(posedge CLK);
        Resetn = 1'b1;

        // ADD 5 + 7, then a reset in the middle of the following cycle.
        @(posedge CLK);
        ALUctr_EX = 4'b0000; busA_EX = 32'd5; busB_EX = 32'd7; Rd_EX = 5'd2; RegWr_EX = 1'b1;
        fire(32'd12, 32'd7);
        #3;
        Resetn = 1'b0;
        #1;
        check("midcycle_reset_exmem", act_pack, 73'd0);
        check("midcycle_reset_stall", 73'(Stall_EX), 73'd0);
        @(posedge CLK);
        Resetn = 1'b1;
        @(posedge CLK);

        // Forwarding priority and register-0 exclusion.
        busA_EX = 32'h11; Rd_EX = 5'd3; RegWr_EX = 1'b1;
        fire(32'h11, 32'h0);
        ALUctr_EX = 4'b0001; Ra_EX = 5'd3; Rb_EX = 5'd3; busA_EX = 32'h55; busB_EX = 32'h66;
        Rd_EX = 5'd3; RegWr_EX = 1'b1; RegWr_WB = 1'b1; Rd_WB = 5'd3; busW_WB = 32'h22;
        fire(32'h0, 32'h11);
        Ra_EX = 5'd3; busA_EX = 32'h55; busB_EX = 32'd5; Rd_EX = 5'd6; RegWr_EX = 1'b1;
        RegWr_WB = 1'b1; Rd_WB = 5'd3; busW_WB = 32'h22;
        fire(32'd5, 32'd5);
        busA_EX = 32'h77; Rd_EX = 5'd0; RegWr_EX = 1'b1;
        fire(32'h77, 32'h0);
        busA_EX = 32'd1; busB_EX = 32'd2; Rd_EX = 5'd9; RegWr_EX = 1'b1;
        RegWr_WB = 1'b1; Rd_WB = 5'd0; busW_WB = 32'h99;
        fire(32'd3, 32'd2);
        Ra_EX = 5'd7; busA_EX = 32'd1; busB_EX = 32'd2; Rd_EX = 5'd10; RegWr_EX = 1'b1;
        RegWr_WB = 1'b1; Rd_WB = 5'd7; busW_WB = 32'h100;
        fire(32'h102, 32'd2);
        // Store: address from immediate, store data forwarded from MEM.
        busA_EX = 32'h1000; imm_EX = 32'h8; ALUBSrc_EX = 2'b01; Rb_EX = 5'd10;
        busB_EX = 32'hdead; MemWr_EX = 1'b1;
        fire(32'h1008, 32'h102);

        // Branches and jump.
        Branch_EX = 1'b1; Ra_EX = 5'd1; Rb_EX = 5'd2; busA_EX = 32'd9; busB_EX = 32'd9;
        PC_EX = 32'h100; imm_EX = 32'h20;
        #1;
        check("beq_taken_redirect", 73'(Redirect_EX), 73'd1);
        check("beq_taken_target", 73'(Target_EX), 73'h120);
        advance();
        Branch_EX = 1'b1; Ra_EX = 5'd1; Rb_EX = 5'd2; busA_EX = 32'd9; busB_EX = 32'd8;
        PC_EX = 32'h100; imm_EX = 32'h20;
        #1;
        check("beq_not_taken_redirect", 73'(Redirect_EX), 73'd0);
        check("beq_not_taken_target", 73'(Target_EX), 73'h120);
        advance();
        Jump_EX = 1'b1; ALUASrc_EX = 1'b1; ALUBSrc_EX = 2'b10; PC_EX = 32'h40;
        imm_EX = 32'h10; Rd_EX = 5'd1; RegWr_EX = 1'b1;
        #1;
        check("jal_redirect", 73'(Redirect_EX), 73'd1);
        check("jal_target", 73'(Target_EX), 73'h50);
        fire(32'h44, 32'h0);

        // Multiply with wraparound.
        ALUctr_EX = 4'b1011; busA_EX = 32'hFFFF_FFFF; busB_EX = 32'd3; Rd_EX = 5'd4;
        RegWr_EX = 1'b1; Jump_EX = 1'b1;
        #1;
        check("mul_no_redirect_while_stalled", 73'(Redirect_EX), 73'd0);
        Jump_EX = 1'b0;
        run_mul("mul_wrap", 32'hFFFF_FFFD, 32'd3);

        // Reset part way through a multiply aborts it.
        ALUctr_EX = 4'b1011; busA_EX = 32'd5; busB_EX = 32'd9; Rd_EX = 5'd4; RegWr_EX = 1'b1;
        repeat (10) @(negedge CLK);
        #2;
        check("busy_stall_before_reset", 73'(Stall_EX), 73'd1);
        Resetn = 1'b0;
        set_nop();
        #1;
        check("busy_reset_exmem", act_pack, 73'd0);
        check("busy_reset_stall", 73'(Stall_EX), 73'd0);
        @(posedge CLK);
        @(posedge CLK);
        Resetn = 1'b1;
        ALUctr_EX = 4'b1011; busA_EX = 32'd6; busB_EX = 32'd7; Rd_EX = 5'd5; RegWr_EX = 1'b1;
        run_mul("mul_6x7", 32'd42, 32'd7);

        // ALU operations.
        alu_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu_op(4'b0111, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_op(4'b0110, 32'h8000_0000, 32'd31, 32'd1);
        alu_op(4'b0101, 32'd1, 32'd31, 32'h8000_0000);
        alu_op(4'b0100, 32'hF0F0, 32'hFF00, 32'h0FF0);
        alu_op(4'b0010, 32'hF0F0, 32'hFF00, 32'hF000);
        alu_op(4'b0011, 32'hF0F0, 32'hFF00, 32'hFFF0);
        alu_op(4'b1110, 32'd2, 32'd3, 32'd5);
        alu_op(4'b0111, 32'h4000_0000, 32'h0000_0022, 32'h1000_0000);
        ALUctr_EX = 4'b1010; ALUBSrc_EX = 2'b11; imm_EX = 32'h1234; busB_EX = 32'h55;
        Rd_EX = 5'd12; RegWr_EX = 1'b1;
        fire(32'h1234, 32'h55);

        repeat (3) @(posedge CLK);
        #2;
        check("queue_drained", 73'(exp_q.size()), 73'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
